// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the combinational ROM and registers
// each returned word with its PC. Supports stall, branch redirect with flush, and halt.
module inst_fetch_unit #(
    parameter int                 ADDR_W    = 16,
    parameter int                 INST_W    = 10,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [INST_W-1:0]  HALT_INST = '0
) (
    input  logic              CLK,
    input  logic              Reset,
    output logic [ADDR_W-1:0] InstAddress,
    input  logic [INST_W-1:0] InstIn,
    input  logic              Stall,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    output logic [INST_W-1:0] InstReg,
    output logic [ADDR_W-1:0] InstPC,
    output logic              InstValid,
    output logic              Halted,
    output logic [15:0]       FetchCount
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [ADDR_W-1:0]  r_pc;
    logic [INST_W-1:0]  r_inst_reg;
    logic [ADDR_W-1:0]  r_inst_pc;
    logic               r_inst_valid;
    logic [15:0]        r_fetch_count;

    logic               w_fetch;
    logic               w_is_halt;
    logic [15:0]        w_count_sat;
    logic [ADDR_W-1:0]  w_pc_inc;

    // A fetch only happens in RUN on a cycle that is neither redirected nor stalled.
    assign w_fetch     = (r_state == ST_RUN) && !BranchTaken && !Stall;
    assign w_is_halt   = (InstIn == HALT_INST);
    assign w_count_sat = (r_fetch_count == 16'hFFFF) ? r_fetch_count : r_fetch_count + 16'd1;
    assign w_pc_inc    = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_fetch && w_is_halt) begin
            w_state_next = ST_HALTED;
        end
    end

    always_comb begin
        InstAddress = r_pc;
        InstReg     = r_inst_reg;
        InstPC      = r_inst_pc;
        InstValid   = r_inst_valid;
        Halted      = (r_state == ST_HALTED);
        FetchCount  = r_fetch_count;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_pc          <= RESET_PC;
            r_inst_reg    <= '0;
            r_inst_pc     <= '0;
            r_inst_valid  <= 1'b0;
            r_fetch_count <= '0;
        end else if (r_state == ST_RUN) begin
            if (BranchTaken) begin
                // Redirect wins over stall; the word being fetched is dropped as a bubble.
                r_pc         <= BranchTarget;
                r_inst_valid <= 1'b0;
            end else if (!Stall) begin
                r_inst_reg <= InstIn;
                r_inst_pc  <= r_pc;
                if (w_is_halt) begin
                    r_inst_valid <= 1'b0;
                end else begin
                    r_inst_valid  <= 1'b1;
                    r_pc          <= w_pc_inc;
                    r_fetch_count <= w_count_sat;
                end
            end
        end else begin
            r_inst_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus randomized stall/branch/reset,
// checked every cycle against a behavioural fetch model; a second instance covers PC wrap.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // main instance: ROM with nonzero words at 0..13, zero beyond
    logic        rst_m, stall, br;
    logic [15:0] tgt;
    logic [15:0] addr_m, ipc_m, cnt_m;
    logic [9:0]  inst_m, ir_m;
    logic        valid_m, halted_m;

    // wrap instance: RESET_PC = FFFE, ROM returns 3FF everywhere
    logic        rst_w;
    logic [15:0] addr_w, ipc_w, cnt_w;
    logic [9:0]  ir_w;
    logic        valid_w, halted_w;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    function automatic logic [9:0] rom_fn(logic [15:0] a);
        if (a < 16'd14) return 10'(a * 16'd71 + 16'd3);
        return 10'd0;
    endfunction

    assign inst_m = rom_fn(addr_m);

    inst_fetch_unit u_main (
        .CLK(clk), .Reset(rst_m), .InstAddress(addr_m), .InstIn(inst_m),
        .Stall(stall), .BranchTaken(br), .BranchTarget(tgt),
        .InstReg(ir_m), .InstPC(ipc_m), .InstValid(valid_m), .Halted(halted_m),
        .FetchCount(cnt_m)
    );

    inst_fetch_unit #(.RESET_PC(16'hFFFE)) u_wrap (
        .CLK(clk), .Reset(rst_w), .InstAddress(addr_w), .InstIn(10'h3FF),
        .Stall(1'b0), .BranchTaken(1'b0), .BranchTarget(16'h0000),
        .InstReg(ir_w), .InstPC(ipc_w), .InstValid(valid_w), .Halted(halted_w),
        .FetchCount(cnt_w)
    );

    typedef struct packed {
        logic        known;
        logic [15:0] pc;
        logic [9:0]  ir;
        logic [15:0] ipc;
        logic        valid;
        logic        halted;
        logic [15:0] cnt;
    } model_t;

    model_t mm = '0;
    model_t mw = '0;

    // One edge of fetch behaviour, straight from the rules: reset, halted, branch, stall, fetch.
    function automatic model_t step(model_t m, logic rst, logic st, logic b,
                                    logic [15:0] t, logic [9:0] word, logic [15:0] rpc);
        model_t n = m;
        if (rst) begin
            n = '0;
            n.known = 1'b1;
            n.pc    = rpc;
        end else if (m.halted) begin
            n.valid = 1'b0;
        end else if (b) begin
            n.pc    = t;
            n.valid = 1'b0;
        end else if (!st) begin
            n.ir  = word;
            n.ipc = m.pc;
            if (word == 10'd0) begin
                n.valid  = 1'b0;
                n.halted = 1'b1;
            end else begin
                n.valid = 1'b1;
                n.pc    = m.pc + 16'd1;
                if (m.cnt != 16'hFFFF) n.cnt = m.cnt + 16'd1;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        mm  <= step(mm, rst_m, stall, br, tgt, rom_fn(mm.pc), 16'h0000);
        mw  <= step(mw, rst_w, 1'b0, 1'b0, 16'h0000, 10'h3FF, 16'hFFFE);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mm.known) begin
            chk("m.addr",   32'(addr_m),   32'(mm.pc));
            chk("m.ir",     32'(ir_m),     32'(mm.ir));
            chk("m.ipc",    32'(ipc_m),    32'(mm.ipc));
            chk("m.valid",  32'(valid_m),  32'(mm.valid));
            chk("m.halted", 32'(halted_m), 32'(mm.halted));
            chk("m.count",  32'(cnt_m),    32'(mm.cnt));
        end
        if (mw.known) begin
            chk("w.addr",   32'(addr_w),   32'(mw.pc));
            chk("w.ipc",    32'(ipc_w),    32'(mw.ipc));
            chk("w.valid",  32'(valid_w),  32'(mw.valid));
            chk("w.halted", 32'(halted_w), 32'(mw.halted));
            chk("w.count",  32'(cnt_w),    32'(mw.cnt));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_reset_main(input string tag);
        chk({tag, ".addr"},   32'(addr_m),   32'h0);
        chk({tag, ".ir"},     32'(ir_m),     32'h0);
        chk({tag, ".ipc"},    32'(ipc_m),    32'h0);
        chk({tag, ".valid"},  32'(valid_m),  32'h0);
        chk({tag, ".halted"}, 32'(halted_m), 32'h0);
        chk({tag, ".count"},  32'(cnt_m),    32'h0);
    endtask

    initial begin
        rst_m = 1'b1; rst_w = 1'b1; stall = 1'b0; br = 1'b0; tgt = 16'h0;
        tick(); tick();
        chk_reset_main("reset0");
        chk("w.reset_addr", 32'(addr_w), 32'hFFFE);
        rst_m = 1'b0; rst_w = 1'b0;

        // free run through the program into the halt word
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("run.ipc",   32'(ipc_m),   32'(i));
            chk("run.ir",    32'(ir_m),    32'(rom_fn(16'(i))));
            chk("run.valid", 32'(valid_m), 32'h1);
            chk("run.count", 32'(cnt_m),   32'(i + 1));
            if (i < 4) begin
                chk("wrap.ipc",   32'(ipc_w),   32'((32'hFFFE + i) & 32'hFFFF));
                chk("wrap.valid", 32'(valid_w), 32'h1);
            end
        end
        $display("run: program 0..13 delivered");
        tick();
        chk("halt.halted", 32'(halted_m), 32'h1);
        chk("halt.valid",  32'(valid_m),  32'h0);
        chk("halt.addr",   32'(addr_m),   32'd14);
        chk("halt.count",  32'(cnt_m),    32'd14);
        br = 1'b1; tgt = 16'd3;
        tick();
        chk("halt.ignore_br", 32'(addr_m), 32'd14);
        br = 1'b0;
        $display("halt: stopped at 14");

        rst_m = 1'b1;
        tick();
        chk_reset_main("reset_halted");
        rst_m = 1'b0;

        // stall three cycles while InstPC=4
        repeat (5) tick();
        chk("pre_stall.ipc", 32'(ipc_m), 32'd4);
        stall = 1'b1;
        repeat (3) begin
            tick();
            chk("stall.ipc",   32'(ipc_m),   32'd4);
            chk("stall.valid", 32'(valid_m), 32'h1);
            chk("stall.addr",  32'(addr_m),  32'd5);
            chk("stall.count", 32'(cnt_m),   32'd5);
        end
        stall = 1'b0;
        tick();
        chk("post_stall.ipc",   32'(ipc_m), 32'd5);
        chk("post_stall.count", 32'(cnt_m), 32'd6);
        $display("stall: held 3 cycles at InstPC=4");

        // branch to 9 while PC=6
        br = 1'b1; tgt = 16'd9;
        tick();
        chk("br.valid", 32'(valid_m), 32'h0);
        chk("br.addr",  32'(addr_m),  32'd9);
        chk("br.count", 32'(cnt_m),   32'd6);
        br = 1'b0;
        tick();
        chk("br2.ipc",   32'(ipc_m),   32'd9);
        chk("br2.valid", 32'(valid_m), 32'h1);
        chk("br2.count", 32'(cnt_m),   32'd7);
        $display("branch: redirected to 9");

        // branch and stall together, target 2, then stall held
        br = 1'b1; stall = 1'b1; tgt = 16'd2;
        tick();
        chk("brst.valid", 32'(valid_m), 32'h0);
        chk("brst.addr",  32'(addr_m),  32'd2);
        br = 1'b0;
        repeat (2) begin
            tick();
            chk("brst_hold.valid", 32'(valid_m), 32'h0);
            chk("brst_hold.addr",  32'(addr_m),  32'd2);
            chk("brst_hold.count", 32'(cnt_m),   32'd7);
        end
        stall = 1'b0;
        tick();
        chk("brst_go.ipc",   32'(ipc_m),   32'd2);
        chk("brst_go.valid", 32'(valid_m), 32'h1);
        $display("branch+stall: branch won, fetch resumed at 2");

        // reset in the middle of a stall
        stall = 1'b1;
        tick();
        rst_m = 1'b1;
        tick();
        chk_reset_main("reset_stall");
        rst_m = 1'b0; stall = 1'b0;
        tick();
        chk("restart.ipc",   32'(ipc_m),   32'd0);
        chk("restart.valid", 32'(valid_m), 32'h1);
        chk("restart.count", 32'(cnt_m),   32'd1);
        $display("reset: mid-stall restart at 0");

        // randomized stall / branch / reset, checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            rst_m = (halted_m && ($urandom % 4 == 0)) || ($urandom % 200 == 0);
            stall = ($urandom % 4 == 0);
            br    = ($urandom % 8 == 0);
            tgt   = 16'($urandom_range(0, 15));
            tick();
        end
        rst_m = 1'b0; stall = 1'b0; br = 1'b0;
        $display("random: 4000 cycles done");

        // let the wrap instance count past 65535 deliveries
        while (cyc < 65600) tick();
        chk("sat.count", 32'(cnt_w),   32'hFFFF);
        chk("sat.valid", 32'(valid_w), 32'h1);
        $display("saturation: FetchCount held at FFFF");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
